// File: rtl/custom_axi_ip_engine.sv
// Job engine behind the AXI register block: steps a seeded accumulator per cycle
// and commits the result to a per-channel result register with status/irq reporting.

package custom_axi_ip_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DONE  = 2'd2,
      ERROR = 2'd3
   } status_e;

   typedef enum logic [1:0] {
      MODE_INC  = 2'd0,
      MODE_DEC  = 2'd1,
      MODE_PASS = 2'd2,
      MODE_RSVD = 2'd3
   } mode_e;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_BAD_MODE = 2'd1;
   localparam logic [1:0] ERR_OVERFLOW = 2'd2;
   localparam logic [1:0] ERR_BAD_CHAN = 2'd3;
endpackage

module custom_axi_ip_engine
   import custom_axi_ip_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned ITER_W     = 8,
   parameter int unsigned STEP       = 1,
   localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         start_i,
   input  logic [CH_W-1:0]              chan_i,
   input  logic [DATA_WIDTH-1:0]        data_i,
   input  logic [ITER_W-1:0]            iter_i,
   input  logic [1:0]                   mode_i,
   input  logic                         ack_i,
   input  logic [NUM_CH-1:0]            clear_i,
   output status_e                      status_o,
   output logic                         busy_o,
   output logic                         irq_o,
   output logic [1:0]                   err_code_o,
   output logic [NUM_CH*DATA_WIDTH-1:0] result_o,
   output logic [NUM_CH-1:0]            result_valid_o
);

   localparam logic [DATA_WIDTH-1:0] STEP_V = DATA_WIDTH'(STEP);

   status_e                             state_q;
   logic [DATA_WIDTH-1:0]               acc_q;
   logic [ITER_W-1:0]                   cnt_q;
   logic [CH_W-1:0]                     chan_q;
   logic [1:0]                          mode_q;
   logic                                busy_q;
   logic                                irq_q;
   logic [1:0]                          err_q;
   logic [NUM_CH-1:0][DATA_WIDTH-1:0]   result_q;
   logic [NUM_CH-1:0]                   valid_q;

   logic [DATA_WIDTH:0]                 inc_sum_c;
   logic                                borrow_c;
   logic                                chan_bad_c;

   // Overflow detection: carry out of the sum, or subtrahend larger than acc.
   always_comb begin
      inc_sum_c  = {1'b0, acc_q} + {1'b0, STEP_V};
      borrow_c   = (acc_q < STEP_V);
      chan_bad_c = (32'(chan_i) >= NUM_CH);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         cnt_q    <= '0;
         chan_q   <= '0;
         mode_q   <= '0;
         busy_q   <= 1'b0;
         irq_q    <= 1'b0;
         err_q    <= ERR_NONE;
         result_q <= '0;
         valid_q  <= '0;
      end else begin
         irq_q   <= 1'b0;
         // A DONE commit below overrides a same-edge clear of that channel.
         valid_q <= valid_q & ~clear_i;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  if (chan_bad_c) begin
                     state_q <= ERROR;
                     err_q   <= ERR_BAD_CHAN;
                     irq_q   <= 1'b1;
                  end else if (mode_i == MODE_RSVD) begin
                     state_q <= ERROR;
                     err_q   <= ERR_BAD_MODE;
                     irq_q   <= 1'b1;
                  end else begin
                     state_q <= BUSY;
                     busy_q  <= 1'b1;
                     acc_q   <= data_i;
                     cnt_q   <= (mode_i == MODE_PASS) ? '0 : iter_i;
                     chan_q  <= chan_i;
                     mode_q  <= mode_i;
                  end
               end
            end
            BUSY: begin
               if (cnt_q == '0) begin
                  state_q          <= DONE;
                  busy_q           <= 1'b0;
                  irq_q            <= 1'b1;
                  result_q[chan_q] <= acc_q;
                  valid_q[chan_q]  <= 1'b1;
               end else if ((mode_q == MODE_INC && inc_sum_c[DATA_WIDTH]) ||
                            (mode_q == MODE_DEC && borrow_c)) begin
                  state_q <= ERROR;
                  busy_q  <= 1'b0;
                  irq_q   <= 1'b1;
                  err_q   <= ERR_OVERFLOW;
               end else begin
                  acc_q <= (mode_q == MODE_INC) ? inc_sum_c[DATA_WIDTH-1:0] : (acc_q - STEP_V);
                  cnt_q <= cnt_q - ITER_W'(1);
               end
            end
            DONE, ERROR: begin
               if (ack_i) begin
                  state_q <= IDLE;
                  err_q   <= ERR_NONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign status_o       = state_q;
   assign busy_o         = busy_q;
   assign irq_o          = irq_q;
   assign err_code_o     = err_q;
   assign result_o       = result_q;
   assign result_valid_o = valid_q;

endmodule

// File: tb/tb_custom_axi_ip_engine.sv
// Self-checking bench for custom_axi_ip_engine: directed vector table, multi-cycle
// corner sequences and randomized jobs against a job-level outcome model.

module tb_custom_axi_ip_engine;
   import custom_axi_ip_pkg::*;

   localparam int NCH   = 3;
   localparam int DW    = 32;
   localparam int IW    = 8;
   localparam int STEPV = 1;
   localparam longint MAXV = 64'hFFFF_FFFF;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [1:0]        chan;
   logic [DW-1:0]     data;
   logic [IW-1:0]     iter;
   logic [1:0]        mode;
   logic              ack;
   logic [NCH-1:0]    clear;
   status_e           status;
   logic              busy;
   logic              irq;
   logic [1:0]        err;
   logic [NCH*DW-1:0] result;
   logic [NCH-1:0]    valid;

   int            n_chk = 0;
   int            n_fail = 0;
   logic [DW-1:0] exp_res [NCH];
   logic [NCH-1:0] exp_valid;

   always #5 clk = ~clk;

   custom_axi_ip_engine #(
      .DATA_WIDTH(DW), .NUM_CH(NCH), .ITER_W(IW), .STEP(STEPV)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .chan_i(chan), .data_i(data),
      .iter_i(iter), .mode_i(mode), .ack_i(ack), .clear_i(clear), .status_o(status),
      .busy_o(busy), .irq_o(irq), .err_code_o(err), .result_o(result),
      .result_valid_o(valid)
   );

   typedef struct {
      int            ch;
      logic [DW-1:0] d;
      int            it;
      int            m;
      status_e       st;
      int            er;
      int            idx;
      logic [DW-1:0] r;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endtask

   function automatic logic [DW-1:0] res_of(input int c);
      return result[c*DW +: DW];
   endfunction

   // Job outcome from the rules: final state, error code, edge index of the
   // terminal transition (start edge = 0) and the committed/retained result.
   task automatic model(input int ch, input logic [DW-1:0] d, input int it, input int m,
                        output status_e st, output int er, output int idx, output logic [DW-1:0] r);
      longint dv = longint'(d);
      longint k;
      st = DONE; er = 0; idx = 1; r = d;
      if (ch >= NCH) begin
         st = ERROR; er = 3; idx = 0; r = '0;
      end else if (m == 3) begin
         st = ERROR; er = 1; idx = 0; r = exp_res[ch];
      end else if (m == 2 || it == 0) begin
         st = DONE; idx = 1; r = d;
      end else if (m == 0) begin
         if (dv + longint'(it) * STEPV > MAXV) begin
            k = (MAXV - dv) / STEPV + 1;
            st = ERROR; er = 2; idx = int'(k); r = exp_res[ch];
         end else begin
            idx = it + 1; r = DW'(dv + longint'(it) * STEPV);
         end
      end else begin
         if (longint'(it) * STEPV > dv) begin
            k = dv / STEPV + 1;
            st = ERROR; er = 2; idx = int'(k); r = exp_res[ch];
         end else begin
            idx = it + 1; r = DW'(dv - longint'(it) * STEPV);
         end
      end
   endtask

   task automatic wait_not_busy(output int idx, output int irq_early);
      idx = 0; irq_early = 0;
      while (status == BUSY && idx < 300) begin
         if (irq) irq_early++;
         @(negedge clk);
         idx++;
      end
   endtask

   task automatic run_job(input int ch, input logic [DW-1:0] d, input int it, input int m,
                          input status_e est, input int eerr, input int eidx,
                          input logic [DW-1:0] er, input string tag);
      int idx, irq_early;
      @(negedge clk);
      start = 1'b1; chan = 2'(ch); data = d; iter = IW'(it); mode = 2'(m);
      @(negedge clk);
      start = 1'b0;
      wait_not_busy(idx, irq_early);
      chk({tag, " status"}, 64'(status), 64'(est));
      chk({tag, " latency"}, 64'(idx), 64'(eidx));
      chk({tag, " irq_early"}, 64'(irq_early), 64'(0));
      chk({tag, " irq"}, 64'(irq), 64'(1));
      chk({tag, " err"}, 64'(err), 64'(eerr));
      if (est == DONE) begin
         exp_res[ch]   = er;
         exp_valid[ch] = 1'b1;
      end
      @(negedge clk);
      chk({tag, " irq_pulse"}, 64'(irq), 64'(0));
      chk({tag, " hold"}, 64'(status), 64'(est));
      if (ch < NCH) chk({tag, " result"}, 64'(res_of(ch)), 64'(er));
      chk({tag, " valid"}, 64'(valid), 64'(exp_valid));
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      chk({tag, " ack_idle"}, 64'(status), 64'(IDLE));
      chk({tag, " ack_err"}, 64'(err), 64'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int idx, irq_early, ch, m, it, sel;
      logic [DW-1:0] d, er;
      status_e est;
      int eerr, eidx;

      vecs[0] = '{2, 32'd10,         3, 0, DONE,  0, 4, 32'd13};
      vecs[1] = '{0, 32'd5,          2, 1, DONE,  0, 3, 32'd3};
      vecs[2] = '{0, 32'd1,          2, 1, ERROR, 2, 2, 32'd3};
      vecs[3] = '{3, 32'd77,         4, 0, ERROR, 3, 0, 32'd0};
      vecs[4] = '{1, 32'd77,         5, 3, ERROR, 1, 0, 32'd0};
      vecs[5] = '{1, 32'hDEADBEEF,   9, 2, DONE,  0, 1, 32'hDEADBEEF};
      vecs[6] = '{1, 32'hCAFE0000,   0, 0, DONE,  0, 1, 32'hCAFE0000};
      vecs[7] = '{2, 32'hFFFFFFFE,   5, 0, ERROR, 2, 2, 32'd13};
      vecs[8] = '{0, 32'hFFFFFFFF,   0, 0, DONE,  0, 1, 32'hFFFFFFFF};

      rst_n = 1'b0; start = 1'b0; chan = '0; data = '0; iter = '0; mode = '0;
      ack = 1'b0; clear = '0;
      for (int c = 0; c < NCH; c++) exp_res[c] = '0;
      exp_valid = '0;
      #1;
      chk("reset status", 64'(status), 64'(IDLE));
      chk("reset outputs", 64'({busy, irq, err, valid}), 64'(0));
      chk("reset result", 64'(result[63:0]) | 64'(result[NCH*DW-1:64]), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++)
         run_job(vecs[i].ch, vecs[i].d, vecs[i].it, vecs[i].m, vecs[i].st, vecs[i].er,
                 vecs[i].idx, vecs[i].r, $sformatf("vec%0d", i));

      // start and ack during BUSY, start during DONE: all dropped
      @(negedge clk);
      start = 1'b1; chan = 2'd2; data = 32'd100; iter = 8'd5; mode = 2'd0;
      @(negedge clk);
      start = 1'b1; ack = 1'b1; chan = 2'd0; data = 32'd7; mode = 2'd2;
      @(negedge clk);
      start = 1'b0; ack = 1'b0;
      chk("busy_ignores busy", 64'(busy), 64'(1));
      wait_not_busy(idx, irq_early);
      chk("busy_ignores status", 64'(status), 64'(DONE));
      chk("busy_ignores result2", 64'(res_of(2)), 64'(100 + 5 * STEPV));
      chk("busy_ignores result0", 64'(res_of(0)), 64'(exp_res[0]));
      exp_res[2] = 32'(100 + 5 * STEPV); exp_valid[2] = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("done_ignores status", 64'(status), 64'(DONE));
      chk("done_ignores result0", 64'(res_of(0)), 64'(exp_res[0]));
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      @(negedge clk);
      chk("no_queued status", 64'(status), 64'(IDLE));
      chk("no_queued busy", 64'(busy), 64'(0));

      // DONE commit on ch1 races a clear of ch1 on the same edge
      start = 1'b1; chan = 2'd1; data = 32'd50; iter = 8'd2; mode = 2'd0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      clear = 3'b010;
      @(negedge clk);
      clear = '0;
      chk("clear_race status", 64'(status), 64'(DONE));
      chk("clear_race valid1", 64'(valid[1]), 64'(1));
      chk("clear_race result1", 64'(res_of(1)), 64'(52));
      exp_res[1] = 32'd52; exp_valid[1] = 1'b1;
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      clear = 3'b010;
      @(negedge clk);
      clear = '0;
      exp_valid[1] = 1'b0;
      chk("clear valid", 64'(valid), 64'(exp_valid));
      chk("clear keeps data", 64'(res_of(1)), 64'(52));

      for (int i = 0; i < 40; i++) begin
         ch  = int'($urandom_range(0, 3));
         m   = int'($urandom_range(0, 3));
         it  = int'($urandom_range(0, 20));
         sel = int'($urandom_range(0, 2));
         if (sel == 0)      d = DW'($urandom_range(0, 10));
         else if (sel == 1) d = 32'hFFFF_FFFF - DW'($urandom_range(0, 10));
         else               d = $urandom;
         model(ch, d, it, m, est, eerr, eidx, er);
         run_job(ch, d, it, m, est, eerr, eidx, er, $sformatf("rnd%0d", i));
      end

      // asynchronous reset in the middle of a job
      @(negedge clk);
      start = 1'b1; chan = 2'd0; data = 32'd0; iter = 8'd10; mode = 2'd0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mid_reset pre busy", 64'(busy), 64'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("mid_reset status", 64'(status), 64'(IDLE));
      chk("mid_reset outputs", 64'({busy, irq, err, valid}), 64'(0));
      chk("mid_reset result", 64'(result[63:0]) | 64'(result[NCH*DW-1:64]), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < NCH; c++) exp_res[c] = '0;
      exp_valid = '0;
      run_job(2, 32'd10, 3, 0, DONE, 0, 4, 32'd13, "post_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
